gpio_cfg_regbank: RTL and testbench

- Parametrised GPIO-driven configuration register bank. It is the next generation of the fixed 16-bit-address / 8-bit-data GPIO write scheme.
- The PS drives a single GPIO word that carries an address field, a data field and a write-strobe bit. The block resynchronises that word, detects strobe rising edges and assembles multi-byte registers from byte-wide writes.
- Each register is committed atomically on the write to its top byte.
- Sits between the PS GPIO and the datapath consumers (MAC/NL input scalers, etc.). One instance is placed per address window.

---
 rtl/gpio_cfg_regbank.sv | 183 ++++++++++++++++++
 tb/tb_gpio_cfg_regbank.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/gpio_cfg_regbank.sv
// GPIO-driven configuration register bank: resynchronises a PS GPIO word, turns strobe
// rises into byte writes and commits each register atomically on its top-byte write.
// Optional readback port enabled by defining GPIO_CFG_ECHO_EN.
module gpio_cfg_regbank #(
  parameter int unsigned GPIO_W        = 32,
  parameter int unsigned W_CLK_BIT     = 24,
  parameter int unsigned ADDR_LO       = 0,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_LO       = 16,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned NUM_REGS      = 4,
  parameter int unsigned BYTES_PER_REG = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [GPIO_W-1:0]                 gpio_in,
  output logic [NUM_REGS*DATA_W*BYTES_PER_REG-1:0] reg_out,
  output logic [NUM_REGS-1:0]               reg_upd,
  output logic                              addr_err
`ifdef GPIO_CFG_ECHO_EN
  ,
  output logic [ADDR_W+DATA_W:0]            gpio_echo
`endif
);

  localparam int unsigned REG_W    = DATA_W * BYTES_PER_REG;
  localparam int unsigned SH_LANES = (BYTES_PER_REG > 1) ? BYTES_PER_REG - 1 : 1;
  localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned LANE_W   = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
  localparam longint unsigned WIN_END =
    64'(BASE_ADDR) + 64'(NUM_REGS) * 64'(BYTES_PER_REG);

  if (WIN_END > (64'd1 << ADDR_W)) begin : g_window_wrap
    $error("gpio_cfg_regbank: address window wraps past 2^ADDR_W");
  end
  if (NUM_REGS < 1 || BYTES_PER_REG < 1) begin : g_bad_geometry
    $error("gpio_cfg_regbank: NUM_REGS and BYTES_PER_REG must be >= 1");
  end

  logic [GPIO_W-1:0] s1_q, s2_q;
  logic              s3_q;
  logic              vld1_q, vld2_q;

  logic [NUM_REGS-1:0][SH_LANES-1:0][DATA_W-1:0] shadow_q, shadow_d;
  logic [SH_LANES-1:0][DATA_W-1:0]               shadow_row_s;
  logic [NUM_REGS*REG_W-1:0] reg_out_q, reg_out_d;
  logic [NUM_REGS-1:0]       reg_upd_q, reg_upd_d;
  logic                      addr_err_q, addr_err_d;

  logic              strobe_edge_s;
  logic [ADDR_W-1:0] addr_s, off_s, quot_s, rem_s;
  logic [DATA_W-1:0] data_s;
  logic              in_range_s, top_lane_s;
  logic [IDX_W-1:0]  idx_s;
  logic [LANE_W-1:0] lane_s;
  logic [REG_W-1:0]  commit_val_s;
  logic              unused_s;

  // Two-flop resynchroniser plus strobe history; the history flop stays high until
  // real samples have reached s2, so a strobe already high at reset release never fires.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= 1'b1;
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
    end else begin
      s1_q   <= gpio_in;
      s2_q   <= s1_q;
      s3_q   <= vld2_q ? s2_q[W_CLK_BIT] : 1'b1;
      vld1_q <= 1'b1;
      vld2_q <= vld1_q;
    end
  end

  assign strobe_edge_s = s2_q[W_CLK_BIT] & ~s3_q;
  assign addr_s        = s2_q[ADDR_LO +: ADDR_W];
  assign data_s        = s2_q[DATA_LO +: DATA_W];
  assign off_s         = addr_s - ADDR_W'(BASE_ADDR);
  assign in_range_s    = (addr_s >= ADDR_W'(BASE_ADDR)) &&
                         ({1'b0, off_s} < (ADDR_W+1)'(NUM_REGS * BYTES_PER_REG));
  assign quot_s        = off_s / ADDR_W'(BYTES_PER_REG);
  assign rem_s         = off_s % ADDR_W'(BYTES_PER_REG);
  assign idx_s         = quot_s[IDX_W-1:0];
  assign lane_s        = rem_s[LANE_W-1:0];
  assign top_lane_s    = (lane_s == LANE_W'(BYTES_PER_REG - 1));
  assign unused_s      = ^{s2_q, quot_s, rem_s};

  // Assemble the commit word from the addressed register's shadow lanes and the new top byte.
  always_comb begin
    shadow_row_s = '0;
    commit_val_s = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (idx_s == IDX_W'(r)) begin
        shadow_row_s = shadow_q[r];
      end else begin
        shadow_row_s = shadow_row_s;
      end
    end
    for (int l = 0; l < BYTES_PER_REG - 1; l++) begin
      commit_val_s[l*DATA_W +: DATA_W] = shadow_row_s[l];
    end
    commit_val_s[(BYTES_PER_REG-1)*DATA_W +: DATA_W] = data_s;
  end

  // Decode one write per strobe edge into a shadow update, a commit or an address error.
  always_comb begin
    shadow_d   = shadow_q;
    reg_out_d  = reg_out_q;
    reg_upd_d  = '0;
    addr_err_d = 1'b0;
    if (strobe_edge_s && !in_range_s) begin
      addr_err_d = 1'b1;
    end else if (strobe_edge_s && top_lane_s) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (idx_s == IDX_W'(r)) begin
          reg_out_d[r*REG_W +: REG_W] = commit_val_s;
          reg_upd_d[r]                = 1'b1;
        end else begin
          reg_upd_d[r] = 1'b0;
        end
      end
    end else if (strobe_edge_s) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int l = 0; l < SH_LANES; l++) begin
          if ((idx_s == IDX_W'(r)) && (lane_s == LANE_W'(l))) begin
            shadow_d[r][l] = data_s;
          end else begin
            shadow_d[r][l] = shadow_q[r][l];
          end
        end
      end
    end else begin
      addr_err_d = 1'b0;
    end
  end

  // Bank state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_q   <= '0;
      reg_out_q  <= '0;
      reg_upd_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      reg_out_q  <= reg_out_d;
      reg_upd_q  <= reg_upd_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign reg_out  = reg_out_q;
  assign reg_upd  = reg_upd_q;
  assign addr_err = addr_err_q;

`ifdef GPIO_CFG_ECHO_EN
  logic [ADDR_W+DATA_W:0] echo_q, echo_d;

  // Readback word: toggle flips on every accepted in-range write.
  always_comb begin
    if (strobe_edge_s && in_range_s) begin
      echo_d = {~echo_q[ADDR_W+DATA_W], addr_s, data_s};
    end else begin
      echo_d = echo_q;
    end
  end

  // Echo register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      echo_q <= '0;
    end else begin
      echo_q <= echo_d;
    end
  end

  assign gpio_echo = echo_q;
`endif

endmodule

// File: tb/tb_gpio_cfg_regbank.sv
// Scoreboard bench for gpio_cfg_regbank: expected pulses are queued at strobe time and
// popped by a negedge monitor whenever reg_upd or addr_err is asserted.
module tb_gpio_cfg_regbank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] gpio_in = 32'd0;
  logic [63:0] reg_out;
  logic [3:0]  reg_upd;
  logic        addr_err;
`ifdef GPIO_CFG_ECHO_EN
  logic [24:0] gpio_echo;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    string       nm;
    logic [3:0]  upd;
    logic        err;
    logic [63:0] regs;
    int          at;
  } exp_t;
  exp_t sb[$];

  gpio_cfg_regbank dut (
    .clk      (clk),
    .rst      (rst),
    .gpio_in  (gpio_in),
    .reg_out  (reg_out),
    .reg_upd  (reg_upd),
    .addr_err (addr_err)
`ifdef GPIO_CFG_ECHO_EN
    ,
    .gpio_echo(gpio_echo)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && (reg_upd != 4'd0 || addr_err)) begin
      if (sb.size() == 0) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL unexpected_pulse: got upd=%b err=%b expected none (cycle %0d)",
                 reg_upd, addr_err, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_upd"},  64'(reg_upd),  64'(e.upd));
        chk({e.nm, "_err"},  64'(addr_err), 64'(e.err));
        chk({e.nm, "_regs"}, reg_out,       e.regs);
        chk({e.nm, "_cyc"},  64'(cyc),      64'(e.at));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One byte write: setup, strobe high for 'hold' cycles, strobe low.
  task automatic wr(input string nm, input logic [15:0] a, input logic [7:0] d,
                    input int hold, input logic [3:0] upd, input logic err,
                    input logic [63:0] regs);
    exp_t e;
    gpio_in = {7'd0, 1'b0, d, a};
    tick(3);
    if (upd != 4'd0 || err) begin
      e.nm = nm; e.upd = upd; e.err = err; e.regs = regs; e.at = cyc + 3;
      sb.push_back(e);
    end
    gpio_in[24] = 1'b1;
    tick(hold);
    gpio_in[24] = 1'b0;
    tick(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    tick(3);
    chk("rst_reg_out",  reg_out,          64'd0);
    chk("rst_reg_upd",  64'(reg_upd),     64'd0);
    chk("rst_addr_err", 64'(addr_err),    64'd0);
    rst = 1'b1;
    tick(4);

    wr("lo_byte", 16'd2, 8'h34, 3, 4'b0000, 1'b0, 64'd0);
    chk("lo_byte_no_commit", reg_out, 64'd0);
    wr("commit_r1", 16'd3, 8'h12, 3, 4'b0010, 1'b0, 64'h0000_0000_1234_0000);
    wr("out_of_range", 16'd8, 8'hFF, 3, 4'b0000, 1'b1, 64'h0000_0000_1234_0000);
    wr("held_strobe", 16'd1, 8'h55, 20, 4'b0001, 1'b0, 64'h0000_0000_1234_5500);

    // Reset mid-sequence clears the pending low byte.
    wr("pre_reset_lo", 16'd0, 8'h77, 3, 4'b0000, 1'b0, 64'd0);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);
    chk("midseq_reset_regs", reg_out, 64'd0);
    wr("post_reset_hi", 16'd1, 8'hAB, 3, 4'b0001, 1'b0, 64'h0000_0000_0000_AB00);

    // Strobe already high across reset release must be ignored until seen low.
    gpio_in = {7'd0, 1'b1, 8'hEE, 16'd7};
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(12);
    chk("armed_no_write", reg_out, 64'd0);
    wr("armed_write", 16'd7, 8'hEE, 3, 4'b1000, 1'b0, 64'hEE00_0000_0000_0000);

`ifdef GPIO_CFG_ECHO_EN
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(3);
    chk("echo_reset", 64'(gpio_echo), 64'd0);
    wr("echo_lo", 16'd4, 8'h9A, 3, 4'b0000, 1'b0, 64'd0);
    wr("echo_hi", 16'd5, 8'hBC, 3, 4'b0100, 1'b0, 64'h0000_BC9A_0000_0000);
    chk("echo_after_two", 64'(gpio_echo), 64'({1'b0, 16'd5, 8'hBC}));
    wr("echo_oor", 16'd9, 8'h11, 3, 4'b0000, 1'b1, 64'h0000_BC9A_0000_0000);
    chk("echo_oor_hold", 64'(gpio_echo), 64'({1'b0, 16'd5, 8'hBC}));
`endif

    tick(5);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
